// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - operator codes, converter states and 7-segment glyphs
package seg7_pkg;

    localparam logic [2:0] ADD      = 3'b000;
    localparam logic [2:0] MINUS    = 3'b001;
    localparam logic [2:0] MULTIPLY = 3'b010;
    localparam logic [2:0] DIVISION = 3'b011;
    localparam logic [2:0] RESET    = 3'b100;
    localparam logic [2:0] EQUAL    = 3'b101;
    localparam logic [2:0] NONE     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } conv_state_e;

    // Bit 0 = segment a ... bit 6 = segment g, 1 = lit
    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_ADD   = 7'h46;
    localparam logic [6:0] GLYPH_MINUS = 7'h40;
    localparam logic [6:0] GLYPH_MUL   = 7'h76;
    localparam logic [6:0] GLYPH_DIV   = 7'h52;
    localparam logic [6:0] GLYPH_RST   = 7'h50;
    localparam logic [6:0] GLYPH_EQUAL = 7'h48;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return GLYPH_0;
            4'd1:    return GLYPH_1;
            4'd2:    return GLYPH_2;
            4'd3:    return GLYPH_3;
            4'd4:    return GLYPH_4;
            4'd5:    return GLYPH_5;
            4'd6:    return GLYPH_6;
            4'd7:    return GLYPH_7;
            4'd8:    return GLYPH_8;
            4'd9:    return GLYPH_9;
            default: return GLYPH_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] op_glyph(input logic [2:0] op);
        case (op)
            ADD:      return GLYPH_ADD;
            MINUS:    return GLYPH_MINUS;
            MULTIPLY: return GLYPH_MUL;
            DIVISION: return GLYPH_DIV;
            RESET:    return GLYPH_RST;
            EQUAL:    return GLYPH_EQUAL;
            default:  return GLYPH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble binary to BCD, one shift per clock
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int SR_W  = 4*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_e      state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SR_W-1:0]  adj;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        count_d = count_q;
        adj     = sr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = {{(4*DIGITS){1'b0}}, bin};
                    count_d = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                // Pre-shift correction keeps every nibble a valid decimal digit after doubling
                for (int i = 0; i < DIGITS; i++) begin
                    if (sr_q[BIN_W+4*i +: 4] >= 4'd5) begin
                        adj[BIN_W+4*i +: 4] = sr_q[BIN_W+4*i +: 4] + 4'd3;
                    end
                end
                sr_d    = {adj[SR_W-2:0], 1'b0};
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(BIN_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            count_q <= count_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign bcd  = sr_q[SR_W-1 -: 4*DIGITS];

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 8-digit multiplexed 7-segment driver with BCD conversion and operator glyph
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int DIGIT_HZ       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] display_number,
    input  logic [2:0]  display_sign,
    output logic [7:0]  seg,
    output logic [7:0]  dig,
    output logic        busy
);

    localparam int         SCAN_DIV = CLK_HZ / DIGIT_HZ;
    localparam int         PRESC_W  = $clog2(SCAN_DIV);
    localparam logic [7:0] SEG_OFF  = {8{SEG_ACTIVE_LOW}};
    localparam logic [7:0] DIG_OFF  = {8{DIG_ACTIVE_LOW}};

    logic [19:0]        last_bin_q, last_bin_d;
    logic [27:0]        bcd_q, bcd_d;
    logic [2:0]         sign_q, sign_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [2:0]         idx_q, idx_d;
    logic               tick_q, tick_d;
    logic [7:0]         seg_q, seg_d;
    logic [7:0]         dig_q, dig_d;

    logic               conv_start, conv_busy, conv_done;
    logic [27:0]        conv_bcd;
    logic [3:0]         nibs [8];
    logic [2:0]         msd;
    logic [6:0]         glyph;

    // A value change during conversion is picked up by this compare once the engine is idle again
    assign conv_start = !conv_busy && (display_number != last_bin_q);

    bin2bcd_seq #(
        .BIN_W  (20),
        .DIGITS (7)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (display_number),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            nibs[i] = bcd_q[4*i +: 4];
        end
        nibs[7] = 4'd0;
        msd = 3'd0;
        for (int i = 1; i < 7; i++) begin
            if (nibs[i] != 4'd0) msd = 3'(i);
        end
        if (idx_q == 3'd7)      glyph = op_glyph(sign_q);
        else if (idx_q > msd)   glyph = GLYPH_BLANK;
        else                    glyph = digit_glyph(nibs[idx_q]);
    end

    always_comb begin
        last_bin_d = conv_start ? display_number : last_bin_q;
        bcd_d      = conv_done ? conv_bcd : bcd_q;
        sign_d     = display_sign;
        tick_d     = (presc_q == PRESC_W'(SCAN_DIV - 1));
        presc_d    = tick_d ? '0 : presc_q + 1'b1;
        idx_d      = tick_d ? idx_q + 3'd1 : idx_q;
        seg_d      = seg_q;
        dig_d      = dig_q;
        if (tick_q) begin
            seg_d = {1'b0, glyph} ^ SEG_OFF;
            dig_d = (8'd1 << idx_q) ^ DIG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_bin_q <= '0;
            bcd_q      <= '0;
            sign_q     <= NONE;
            presc_q    <= '0;
            idx_q      <= '0;
            tick_q     <= 1'b0;
            seg_q      <= SEG_OFF;
            dig_q      <= DIG_OFF;
        end else begin
            last_bin_q <= last_bin_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            tick_q     <= tick_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

    assign seg  = seg_q;
    assign dig  = dig_q;
    assign busy = conv_busy;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - randomized and directed bench with a behavioural display model
module tb_seg7_scan_display;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] din = '0;
    logic [2:0]  dsign = 3'b111;
    logic [7:0]  seg, dig;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    seg7_scan_display #(
        .CLK_HZ         (SD * 1000),
        .DIGIT_HZ       (1000),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .display_number (din),
        .display_sign   (dsign),
        .seg            (seg),
        .dig            (dig),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    string dec_set [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    string op_set  [8]  = '{"bcg", "g", "bcefg", "beg", "eg", "dg", "", ""};

    function automatic logic [6:0] letters(input string s);
        logic [6:0] b = '0;
        for (int i = 0; i < s.len(); i++) b[s[i] - 8'd97] = 1'b1;
        return b;
    endfunction

    function automatic logic [7:0] render(input int idx, input int val, input logic [2:0] s);
        logic [6:0] g;
        int p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (idx == 7)                 g = letters(op_set[s]);
        else if (idx > 0 && val < p)  g = 7'h00;
        else                          g = letters(dec_set[(val / p) % 10]);
        return ~{1'b0, g};
    endfunction

    // Model: converter as "value latched, visible 21 edges later"; scan as arithmetic on edge count
    int         m_last, m_left, m_pend, m_val, m_n, m_idx;
    bit         m_tick, m_valid = 0;
    logic [2:0] m_sign;
    logic [7:0] e_seg, e_dig;

    always @(posedge clk) begin
        if (rst) begin
            m_last = 0; m_left = 0; m_pend = 0; m_val = 0; m_sign = 3'b111;
            m_n = 0; m_tick = 0; m_idx = 0;
            e_seg = 8'hFF; e_dig = 8'hFF; m_valid = 1;
        end else begin
            if (m_tick) begin
                e_seg = render(m_idx, m_val, m_sign);
                e_dig = ~(8'd1 << m_idx);
            end
            if (m_left == 0) begin
                if (int'(din) != m_last) begin
                    m_last = int'(din); m_pend = int'(din); m_left = 21;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_val = m_pend;
            end
            m_sign = dsign;
            m_n++;
            m_tick = (m_n % SD == 0);
            m_idx  = (m_n / SD) % 8;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("seg_model", 32'(seg), 32'(e_seg));
            check("dig_model", 32'(dig), 32'(e_dig));
            check("busy_model", 32'(busy), 32'(m_left != 0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_dig(input int i, input logic [7:0] exp, input string nm);
        logic [7:0] tgt = ~(8'd1 << i);
        int k = 0;
        while (dig == tgt && k < 200) begin @(negedge clk); k++; end
        while (dig != tgt && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) begin
            n_checks++;
            $display("FAIL %s: digit %0d never selected, got dig %0h", nm, i, dig);
        end else begin
            check(nm, 32'(seg), 32'(exp));
        end
    endtask

    task automatic wait_busy(input string nm);
        int k = 0;
        while (!busy && k < 10) begin @(negedge clk); k++; end
        if (k >= 10) begin
            n_checks++;
            $display("FAIL %s: busy never rose, got %0b expected 1", nm, busy);
        end
    endtask

    initial begin
        int len;
        int vals [6] = '{0, 1048575, 9, 10, 99999, 100000};

        step(3);
        rst = 1'b0;
        check("reset_seg", 32'(seg), 32'hFF);
        check("reset_dig", 32'(dig), 32'hFF);
        check("reset_busy", 32'(busy), 32'h0);

        wait_dig(0, 8'hC0, "zero_glyph");
        wait_dig(1, 8'hFF, "zero_d1_blank");
        wait_dig(7, 8'hFF, "sign_none_blank");

        din = 20'd12345; dsign = 3'b000;
        step(1);
        wait_busy("busy_rise_12345");
        len = 0;
        while (busy && len < 100) begin @(negedge clk); len++; end
        check("busy_len", 32'(len), 32'd21);
        wait_dig(0, 8'h92, "d0_is_5");
        wait_dig(4, 8'hF9, "d4_is_1");
        wait_dig(5, 8'hFF, "d5_blank");
        wait_dig(7, 8'hB9, "add_glyph");

        din = 20'd1048575;
        step(30);
        wait_dig(3, 8'h80, "max_d3_is_8");
        wait_dig(5, 8'hC0, "max_inner_zero");
        wait_dig(6, 8'hF9, "max_d6_is_1");

        din = 20'd7;
        step(1);
        wait_busy("busy_rise_7");
        step(10);
        din = 20'd900;
        step(60);
        wait_dig(2, 8'h90, "d2_is_9");
        wait_dig(0, 8'hC0, "d0_of_900");

        din = 20'd55555;
        step(1);
        wait_busy("busy_rise_55555");
        step(5);
        rst = 1'b1;
        step(1);
        check("rst_mid_seg", 32'(seg), 32'hFF);
        check("rst_mid_dig", 32'(dig), 32'hFF);
        check("rst_mid_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step(60);

        for (int s = 0; s < 8; s++) begin
            dsign = 3'(s);
            step(40);
            if (s == 5) wait_dig(7, 8'hB7, "equal_glyph");
            if (s == 6) wait_dig(7, 8'hFF, "code110_blank");
        end

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) din = 20'(vals[$urandom_range(0, 5)]);
            else                           din = 20'($urandom_range(0, 1048575));
            dsign = 3'($urandom_range(0, 7));
            step($urandom_range(5, 60));
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
        end
        step(80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
